c1541_ram_arbiter: RTL and testbench
====================================

Name: c1541_ram_arbiter

Overview:
- Shares the drive's 2 KB work RAM, a single-port synchronous RAM with 1-cycle read latency, between two requesters:
  - the 6502 CPU, on its fixed bus slot;
  - a host-side port, used for save-state, debugger and snooping accesses, with a req/ack handshake.
- The CPU always owns the RAM in its slot cycle. Host accesses are scheduled into free `clk` cycles between CPU slots, so CPU timing is never disturbed.
- Sits between the drive core's memory-address register stage and the RAM instance.

Parameters:
- ADDR_W, 11, RAM address width (2 KB).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_slot  in  1  one-cycle strobe aligned with the CPU address phase (p2_h_r); CPU addresses RAM this cycle.
- cpu_addr  in  ADDR_W  CPU RAM address, valid with cpu_slot.
- cpu_we  in  1  CPU write enable (already qualified with ram chip-select), valid with cpu_slot.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; held until the next CPU read result.
- host_req  in  1  host access request; sampled only while host_busy=0.
- host_we  in  1  host write when 1, read when 0.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_busy  out  1  request accepted and not yet acknowledged.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_W  host read data; valid from host_ack, held until the next host read ack.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM registered output; reflects the address of the previous cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE;
  - host_busy=0, host_ack=0, host_rdata=0, cpu_rdata=0;
  - internal cpu_pend=0 and host_pend=0;
  - mem_we=0 while in reset.
  - A request in flight when reset asserts is aborted: no ack, no write.
- Memory mux (combinational, one RAM access per cycle):
  - cpu_slot=1: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
  - else if state=ISSUE: drive latched host address, write enable and data.
  - else: mem_addr holds the last driven value, mem_we=0.
- CPU read pipeline:
  - cpu_pend <= cpu_slot & ~cpu_we.
  - In the cycle with cpu_pend=1, cpu_rdata <= mem_rdata at the edge ending that cycle.
  - CPU writes do not update cpu_rdata.
- Host FSM:
  - IDLE: on host_req=1, latch we/addr/wdata, set host_busy=1, go to ISSUE. No ack in this cycle.
  - ISSUE: if cpu_slot=1, stay (CPU wins). Otherwise perform the access and go to CAPTURE.
  - CAPTURE:
    - if a host read, host_rdata <= mem_rdata at the end of this cycle;
    - next cycle: host_ack=1, host_busy=0, back to IDLE.
    - cpu_slot in this cycle is legal and served normally.
  - Minimum latency: req sampled in cycle 0 → ack high in cycle 3. Each cpu_slot hit in ISSUE adds 1 cycle.
  - A new host_req is accepted in the ack cycle itself, since state is IDLE then; back-to-back throughput is 1 access per 3 cycles.
- Ordering:
  - Accesses take effect in RAM in mux order.
  - A CPU write and a host write to the same address in consecutive cycles: the later cycle wins.
  - A host read issued the cycle after a CPU write returns the new data.
- No host starvation: cpu_slot occurs at most 1 in every 16 ce cycles.
- host_req held high during busy is ignored; it is not queued.

Decomposition:
- Shared package c1541_pkg:
  - host state enum {IDLE, ISSUE, CAPTURE};
  - RAM_ADDR_W=11 and RAM_DATA_W=8 constants (defaults for the parameters).
- No sub-module: the FSM, mux and capture registers stay in one module.
- The RAM stays the existing dual-port memory primitive, instantiated by the parent with port B unused.

Test Plan:
- Reset: assert reset mid-ISSUE with host write to 0x010 → no ack; mem_we=0; RAM[0x010] unchanged; all outputs 0.
- CPU read: preload RAM[0x123]=0x5A; cpu_slot with addr 0x123, we=0 → mem_addr=0x123 that cycle; cpu_rdata=0x5A from 2 cycles after slot, held until the next CPU read.
- Host read, idle bus: RAM[0x7FF]=0xC3; host_req at cycle 0 → mem_addr=0x7FF in cycle 1; host_ack in cycle 3; host_rdata=0xC3; host_busy high in cycles 1–2.
- Collision: host_req in cycle 0 and cpu_slot (write 0x020←0x11) in cycle 1; host write 0x020←0x22 → CPU writes in cycle 1, host in cycle 2, ack in cycle 4; final RAM[0x020]=0x22.
- CAPTURE overlap: host read of 0x040 (=0x99) with cpu_slot read of 0x041 (=0x77) in the CAPTURE cycle → host_rdata=0x99, cpu_rdata=0x77; no corruption.
- Throughput: host_req held high for 30 cycles, no CPU slots → exactly 10 acks, 3 cycles apart.

Source files
------------

// File: rtl/c1541_ram_arbiter_pkg.sv
// c1541_pkg: shared types and default widths for the drive work-RAM arbiter.
package c1541_pkg;
   localparam int RAM_ADDR_W = 11;
   localparam int RAM_DATA_W = 8;
   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} host_state_e;
endpackage

// File: rtl/c1541_ram_arbiter.sv
// c1541_ram_arbiter: shares the 2 KB work RAM between the CPU bus slot and a host req/ack port.
module c1541_ram_arbiter
   import c1541_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_slot,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_busy,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   host_state_e       state_q, state_d;
   logic [ADDR_W-1:0] h_addr_q, h_addr_d, addr_q;
   logic [DATA_W-1:0] h_wdata_q, h_wdata_d, cpu_rdata_q, host_rdata_q;
   logic              h_we_q, h_we_d, ack_q, ack_d, cpu_pend_q, host_go;
   // The CPU always owns its slot; the host only reaches the RAM in a free ISSUE cycle.
   assign host_go   = (state_q == ISSUE) && !cpu_slot;
   assign mem_addr  = cpu_slot ? cpu_addr : host_go ? h_addr_q : addr_q;
   assign mem_we    = !reset && (cpu_slot ? cpu_we : host_go && h_we_q);
   assign mem_wdata = cpu_slot ? cpu_wdata : h_wdata_q;
   assign host_busy = state_q != IDLE;
   assign host_ack  = ack_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign host_rdata = host_rdata_q;
   always_comb begin
      state_d   = state_q;
      h_addr_d  = h_addr_q;
      h_we_d    = h_we_q;
      h_wdata_d = h_wdata_q;
      ack_d     = 1'b0;
      case (state_q)
         IDLE: if (host_req) begin
            h_addr_d  = host_addr;
            h_we_d    = host_we;
            h_wdata_d = host_wdata;
            state_d   = ISSUE;
         end
         ISSUE: state_d = cpu_slot ? ISSUE : CAPTURE;
         CAPTURE: begin
            state_d = IDLE;
            ack_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         h_addr_q     <= '0;
         h_we_q       <= 1'b0;
         h_wdata_q    <= '0;
         ack_q        <= 1'b0;
         addr_q       <= '0;
         cpu_pend_q   <= 1'b0;
         cpu_rdata_q  <= '0;
         host_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         h_addr_q   <= h_addr_d;
         h_we_q     <= h_we_d;
         h_wdata_q  <= h_wdata_d;
         ack_q      <= ack_d;
         addr_q     <= mem_addr;
         cpu_pend_q <= cpu_slot && !cpu_we;
         if (cpu_pend_q) cpu_rdata_q <= mem_rdata;
         if (state_q == CAPTURE && !h_we_q) host_rdata_q <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_c1541_ram_arbiter.sv
// tb_c1541_ram_arbiter: directed scenarios plus a randomized run against a timestamped access model.
module tb_c1541_ram_arbiter;
   logic        clk = 1'b0, reset = 1'b1;
   logic        cpu_slot = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
   logic [10:0] cpu_addr = '0, host_addr = '0, mem_addr;
   logic [7:0]  cpu_wdata = '0, host_wdata = '0, cpu_rdata, host_rdata, mem_wdata, mem_rdata;
   logic        host_busy, host_ack, mem_we;
   logic [7:0]  ram [0:2047];
   logic        bd_we = 1'b0;
   logic [10:0] bd_addr = '0;
   logic [7:0]  bd_data = '0;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   c1541_ram_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_slot(cpu_slot), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_busy(host_busy), .host_ack(host_ack), .host_rdata(host_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );
   // Single-port synchronous RAM with a backdoor preload port for the bench.
   always @(posedge clk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in();
      cpu_slot = 1'b0; cpu_we = 1'b0; host_req = 1'b0; host_we = 1'b0;
   endtask
   task automatic poke(input logic [10:0] a, input logic [7:0] d);
      nxt(); bd_we = 1'b1; bd_addr = a; bd_data = d;
      nxt(); bd_we = 1'b0;
   endtask
   task automatic test_reset();
      bit saw_ack;
      reset = 1'b1; idle_in();
      @(negedge clk);
      checks += 4;
      if (host_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", host_busy); end
      if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", host_ack); end
      if (host_rdata !== 8'h00 || cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=00/00", host_rdata, cpu_rdata); end
      if (mem_we !== 1'b0 || mem_addr !== 11'h0) begin errors++; $display("FAIL rst_mem got=%b/%h exp=0/000", mem_we, mem_addr); end
      nxt(); reset = 1'b0;
      poke(11'h010, 8'h33);
      nxt(); host_req = 1'b1; host_we = 1'b1; host_addr = 11'h010; host_wdata = 8'hEE;
      nxt(); host_req = 1'b0; cpu_slot = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h200;
      #2 reset = 1'b1; cpu_slot = 1'b0;
      @(negedge clk);
      checks += 2;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_abort_we got=%b exp=0", mem_we); end
      if (host_busy !== 1'b0) begin errors++; $display("FAIL rst_abort_busy got=%b exp=0", host_busy); end
      nxt(); nxt(); reset = 1'b0;
      saw_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         nxt(); @(negedge clk);
         if (host_ack) saw_ack = 1'b1;
      end
      checks += 3;
      if (saw_ack) begin errors++; $display("FAIL rst_no_ack got=1 exp=0"); end
      if (ram[11'h010] !== 8'h33) begin errors++; $display("FAIL rst_ram got=%h exp=33", ram[11'h010]); end
      if (host_busy !== 1'b0 || host_rdata !== 8'h00) begin errors++; $display("FAIL rst_after got=%b/%h exp=0/00", host_busy, host_rdata); end
   endtask
   task automatic test_cpu_read();
      poke(11'h123, 8'h5A);
      nxt(); cpu_slot = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
      @(negedge clk);
      checks += 2;
      if (mem_addr !== 11'h123) begin errors++; $display("FAIL cpu_rd_addr got=%h exp=123", mem_addr); end
      if (mem_we !== 1'b0) begin errors++; $display("FAIL cpu_rd_we got=%b exp=0", mem_we); end
      nxt(); cpu_slot = 1'b0;
      @(negedge clk);
      checks++;
      if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL cpu_rd_early got=%h exp=00", cpu_rdata); end
      nxt(); @(negedge clk);
      checks++;
      if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL cpu_rd_data got=%h exp=5a", cpu_rdata); end
      nxt(); cpu_slot = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h124; cpu_wdata = 8'hFF;
      nxt(); idle_in(); nxt(); nxt(); @(negedge clk);
      checks++;
      if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL cpu_rd_hold got=%h exp=5a", cpu_rdata); end
   endtask
   task automatic test_host_read();
      poke(11'h7FF, 8'hC3);
      nxt(); host_req = 1'b1; host_we = 1'b0; host_addr = 11'h7FF;
      @(negedge clk);
      checks++;
      if (host_busy !== 1'b0 || host_ack !== 1'b0) begin errors++; $display("FAIL hr_c0 got=%b/%b exp=0/0", host_busy, host_ack); end
      nxt(); host_req = 1'b0;
      @(negedge clk);
      checks += 2;
      if (mem_addr !== 11'h7FF || mem_we !== 1'b0) begin errors++; $display("FAIL hr_c1_mem got=%h/%b exp=7ff/0", mem_addr, mem_we); end
      if (host_busy !== 1'b1) begin errors++; $display("FAIL hr_c1_busy got=%b exp=1", host_busy); end
      nxt(); @(negedge clk);
      checks += 2;
      if (host_busy !== 1'b1 || host_ack !== 1'b0) begin errors++; $display("FAIL hr_c2 got=%b/%b exp=1/0", host_busy, host_ack); end
      if (mem_addr !== 11'h7FF) begin errors++; $display("FAIL hr_c2_hold got=%h exp=7ff", mem_addr); end
      nxt(); @(negedge clk);
      checks += 2;
      if (host_ack !== 1'b1 || host_busy !== 1'b0) begin errors++; $display("FAIL hr_c3 got=%b/%b exp=1/0", host_ack, host_busy); end
      if (host_rdata !== 8'hC3) begin errors++; $display("FAIL hr_data got=%h exp=c3", host_rdata); end
      nxt(); @(negedge clk);
      checks++;
      if (host_ack !== 1'b0 || host_rdata !== 8'hC3) begin errors++; $display("FAIL hr_c4 got=%b/%h exp=0/c3", host_ack, host_rdata); end
   endtask
   task automatic test_collision();
      poke(11'h020, 8'h00);
      nxt(); host_req = 1'b1; host_we = 1'b1; host_addr = 11'h020; host_wdata = 8'h22;
      nxt(); host_req = 1'b0; cpu_slot = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h020; cpu_wdata = 8'h11;
      @(negedge clk);
      checks += 2;
      if (mem_addr !== 11'h020 || mem_we !== 1'b1 || mem_wdata !== 8'h11) begin errors++; $display("FAIL col_cpu got=%h/%b/%h exp=020/1/11", mem_addr, mem_we, mem_wdata); end
      if (host_busy !== 1'b1) begin errors++; $display("FAIL col_busy got=%b exp=1", host_busy); end
      nxt(); idle_in();
      @(negedge clk);
      checks++;
      if (mem_addr !== 11'h020 || mem_we !== 1'b1 || mem_wdata !== 8'h22) begin errors++; $display("FAIL col_host got=%h/%b/%h exp=020/1/22", mem_addr, mem_we, mem_wdata); end
      nxt(); @(negedge clk);
      checks++;
      if (host_ack !== 1'b0) begin errors++; $display("FAIL col_c3_ack got=%b exp=0", host_ack); end
      nxt(); @(negedge clk);
      checks += 2;
      if (host_ack !== 1'b1) begin errors++; $display("FAIL col_c4_ack got=%b exp=1", host_ack); end
      if (ram[11'h020] !== 8'h22) begin errors++; $display("FAIL col_ram got=%h exp=22", ram[11'h020]); end
   endtask
   task automatic test_capture_overlap();
      poke(11'h040, 8'h99);
      poke(11'h041, 8'h77);
      nxt(); host_req = 1'b1; host_we = 1'b0; host_addr = 11'h040;
      nxt(); host_req = 1'b0;
      nxt(); cpu_slot = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h041;
      @(negedge clk);
      checks++;
      if (mem_addr !== 11'h041) begin errors++; $display("FAIL cap_addr got=%h exp=041", mem_addr); end
      nxt(); idle_in();
      @(negedge clk);
      checks++;
      if (host_ack !== 1'b1 || host_rdata !== 8'h99) begin errors++; $display("FAIL cap_host got=%b/%h exp=1/99", host_ack, host_rdata); end
      nxt(); @(negedge clk);
      checks += 2;
      if (cpu_rdata !== 8'h77) begin errors++; $display("FAIL cap_cpu got=%h exp=77", cpu_rdata); end
      if (host_rdata !== 8'h99) begin errors++; $display("FAIL cap_host_hold got=%h exp=99", host_rdata); end
   endtask
   task automatic test_back_to_back();
      int n_ack, first, last, bad_gap;
      n_ack = 0; first = -1; last = -1; bad_gap = 0;
      for (int n = 0; n < 36; n++) begin
         nxt(); host_req = n < 30; host_we = 1'b0; host_addr = 11'(n);
         @(negedge clk);
         if (host_ack) begin
            if (first < 0) first = n;
            if (last >= 0 && n - last != 3) bad_gap++;
            last = n; n_ack++;
         end
      end
      idle_in();
      checks += 3;
      if (n_ack != 10) begin errors++; $display("FAIL b2b_count got=%0d exp=10", n_ack); end
      if (first != 3) begin errors++; $display("FAIL b2b_first got=%0d exp=3", first); end
      if (bad_gap != 0) begin errors++; $display("FAIL b2b_gap got=%0d bad exp=0", bad_gap); end
   endtask
   task automatic test_random();
      localparam int N = 600;
      logic [7:0] ref_mem [0:15];
      logic [7:0] exp_crd, exp_hrd, crd_val, m_val, m_wd, exp_wd;
      logic [10:0] m_addr, exp_addr;
      bit crd_ok, hrd_ok, infl, done, m_we, s, exp_act, exp_we, exp_ack;
      int ack_at, crd_at, last_slot, ram_bad;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 8'($urandom);
         poke(11'h100 | 11'(i), ref_mem[i]);
      end
      crd_ok = 0; hrd_ok = 0; infl = 0; done = 0; ack_at = -100; crd_at = -100; last_slot = -100;
      for (int n = 0; n < N; n++) begin
         nxt();
         s = (n - last_slot >= 4) && (n < N - 12) && ($urandom_range(0, 3) == 0);
         if (s) last_slot = n;
         cpu_slot = s; cpu_we = 1'($urandom); cpu_addr = 11'h100 | 11'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
         host_req = (n < N - 12) && ($urandom_range(0, 1) == 1); host_we = 1'($urandom);
         host_addr = 11'h100 | 11'($urandom_range(0, 15)); host_wdata = 8'($urandom);
         @(negedge clk);
         exp_ack = (n == ack_at);
         if (exp_ack) begin
            infl = 0;
            if (!m_we) begin exp_hrd = m_val; hrd_ok = 1; end
         end
         if (n == crd_at) begin exp_crd = crd_val; crd_ok = 1; end
         checks += 2;
         if (host_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, host_ack, exp_ack); end
         if (host_busy !== infl) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, host_busy, infl); end
         if (crd_ok) begin
            checks++;
            if (cpu_rdata !== exp_crd) begin errors++; $display("FAIL rnd_cpu_rdata n=%0d got=%h exp=%h", n, cpu_rdata, exp_crd); end
         end
         if (hrd_ok) begin
            checks++;
            if (host_rdata !== exp_hrd) begin errors++; $display("FAIL rnd_host_rdata n=%0d got=%h exp=%h", n, host_rdata, exp_hrd); end
         end
         exp_act = 0; exp_we = 0; exp_addr = '0; exp_wd = '0;
         if (s) begin
            exp_act = 1; exp_we = cpu_we; exp_addr = cpu_addr; exp_wd = cpu_wdata;
            if (cpu_we) ref_mem[cpu_addr[3:0]] = cpu_wdata;
            else begin crd_at = n + 2; crd_val = ref_mem[cpu_addr[3:0]]; end
         end else if (infl && !done) begin
            done = 1; ack_at = n + 2;
            exp_act = 1; exp_we = m_we; exp_addr = m_addr; exp_wd = m_wd;
            if (m_we) ref_mem[m_addr[3:0]] = m_wd;
            else m_val = ref_mem[m_addr[3:0]];
         end
         checks++;
         if (mem_we !== exp_we) begin errors++; $display("FAIL rnd_mem_we n=%0d got=%b exp=%b", n, mem_we, exp_we); end
         if (exp_act) begin
            checks++;
            if (mem_addr !== exp_addr || (exp_we && mem_wdata !== exp_wd)) begin
               errors++; $display("FAIL rnd_mem_bus n=%0d got=%h/%h exp=%h/%h", n, mem_addr, mem_wdata, exp_addr, exp_wd);
            end
         end
         if (!infl && host_req) begin
            infl = 1; done = 0; m_we = host_we; m_addr = host_addr; m_wd = host_wdata;
         end
      end
      idle_in();
      nxt(); nxt();
      ram_bad = 0;
      for (int i = 0; i < 16; i++) if (ram[11'h100 | 11'(i)] !== ref_mem[i]) ram_bad++;
      checks++;
      if (ram_bad != 0) begin errors++; $display("FAIL rnd_ram_contents got=%0d wrong exp=0", ram_bad); end
   endtask
   initial begin
      test_reset();
      test_cpu_read();
      test_host_read();
      test_collision();
      test_capture_overlap();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
